mips_multicycle_ctrl: RTL and testbench

//  Main control FSM plus ALU decoder for the multicycle MIPS core.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 55 +++++
 rtl/mips_multicycle_ctrl_if.sv | 39 +++
 rtl/mips_multicycle_ctrl_aludec.sv | 38 +++
 rtl/mips_multicycle_ctrl.sv | 125 ++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// ============================================================
// Package : mips_mc_pkg
// Brief   : State, ALU-op and opcode/funct constants for the multicycle MIPS control.
// Rev     : 1.0
// ============================================================
`default_nettype none

package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_BRANCHNE = 4'd12,
    S_HALT     = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
// ============================================================
// Interface : mips_multicycle_ctrl_if
// Brief     : Control-to-datapath bundle; master = controller, slave = datapath.
// Rev       : 1.0
// ============================================================
`default_nettype none

interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state_o
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state_o
  );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ============================================================
// Module : mips_aludec
// Brief  : Combinational ALU decoder, (aluop, funct) -> alucontrol.
// Rev    : 1.0
// ============================================================
`default_nettype none

module mips_aludec
  import mips_mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unknown funct falls back to add; the instruction still writes back.
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================
// Module : mips_multicycle_ctrl
// Brief  : Main control FSM + ALU decoder of the multicycle MIPS core.
//          Optional bne support via `define MIPS_MC_BNE_EN.
// Rev    : 1.0
// ============================================================
`default_nettype none

module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_ctrl_if.master        bus
);

  state_t     state, next_state;
  aluop_t     aluop;
  logic       pcwrite, branch, irwrite, regwrite, memwrite;
  logic       iord, memtoreg, regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       branch_taken;
`ifdef MIPS_MC_BNE_EN
  logic       branchne;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    illegal    = 1'b0;
`ifdef MIPS_MC_BNE_EN
    branchne   = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       next_state = S_BRANCHNE;
`endif
          default: begin
            illegal    = 1'b1;
            next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1; alusrcb = 2'b10;
        next_state = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD:  begin iord = 1'b1; next_state = S_MEMWB; end
      S_MEMWB:  begin regwrite = 1'b1; memtoreg = 1'b1; end
      S_MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
      S_EXEC:   begin alusrca = 1'b1; aluop = ALUOP_FUNCT; next_state = S_ALUWB; end
      S_ALUWB:  begin regwrite = 1'b1; regdst = 1'b1; end
      S_BRANCH: begin alusrca = 1'b1; aluop = ALUOP_SUB; branch = 1'b1; pcsrc = 2'b01; end
      S_ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; next_state = S_ADDIWB; end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP:   begin pcwrite = 1'b1; pcsrc = 2'b10; end
`ifdef MIPS_MC_BNE_EN
      S_BRANCHNE: begin alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = 2'b01; branchne = 1'b1; end
`endif
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

`ifdef MIPS_MC_BNE_EN
  assign branch_taken = (branch & bus.zero) | (branchne & ~bus.zero);
`else
  assign branch_taken = branch & bus.zero;
`endif

  mips_aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol)
  );

  // Write strobes are masked during reset so an aborted instruction leaves no partial write.
  assign bus.pcen       = (pcwrite | branch_taken) & ~reset;
  assign bus.memwrite   = memwrite & ~reset;
  assign bus.irwrite    = irwrite & ~reset;
  assign bus.regwrite   = regwrite & ~reset;
  assign bus.iord       = iord;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.illegal    = illegal;
  assign bus.state_o    = state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================
// Module : tb_mips_multicycle_ctrl
// Brief  : Scoreboard bench for mips_multicycle_ctrl; ILLEGAL_HALT=0 and =1 instances side by side.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus0 ();
  mips_multicycle_ctrl_if bus1 ();

  mips_multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
  mips_multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rst;
    int         st0;
    int         st1;
  } ent_t;

  ent_t sbq[$];
  bit   halted1 = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  wire [15:0] obs0 = {bus0.pcen, bus0.memwrite, bus0.irwrite, bus0.regwrite, bus0.iord,
                      bus0.memtoreg, bus0.regdst, bus0.alusrca, bus0.alusrcb, bus0.pcsrc,
                      bus0.alucontrol, bus0.illegal};
  wire [15:0] obs1 = {bus1.pcen, bus1.memwrite, bus1.irwrite, bus1.regwrite, bus1.iord,
                      bus1.memtoreg, bus1.regdst, bus1.alusrca, bus1.alusrcb, bus1.pcsrc,
                      bus1.alucontrol, bus1.illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef MIPS_MC_BNE_EN
      6'b000101: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Reference outputs for a given state, straight from the state/output table.
  function automatic logic [15:0] model(input int st, input logic [5:0] op, input logic [5:0] funct,
                                        input logic zero, input logic rst);
    logic pcw, br, bne, irw, rw, mw, iord, m2r, rd, a, ill, pcen;
    logic [1:0] bsel, psel, aop;
    logic [2:0] ac;
    {pcw, br, bne, irw, rw, mw, iord, m2r, rd, a, ill} = '0;
    bsel = 2'b00; psel = 2'b00; aop = 2'b00;
    case (st)
      0:  begin irw = 1; pcw = 1; bsel = 2'b01; end
      1:  begin bsel = 2'b11; ill = !is_legal(op); end
      2:  begin a = 1; bsel = 2'b10; end
      3:  iord = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin a = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin a = 1; aop = 2'b01; br = 1; psel = 2'b01; end
      9:  begin a = 1; bsel = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; psel = 2'b10; end
`ifdef MIPS_MC_BNE_EN
      12: begin a = 1; aop = 2'b01; psel = 2'b01; bne = 1; end
`endif
      default: ;
    endcase
    case (aop)
      2'b01: ac = 3'b110;
      2'b10: case (funct)
               6'b100010: ac = 3'b110;
               6'b100100: ac = 3'b000;
               6'b100101: ac = 3'b001;
               6'b101010: ac = 3'b111;
               default:   ac = 3'b010;
             endcase
      default: ac = 3'b010;
    endcase
    pcen = pcw | (br & zero) | (bne & ~zero);
    if (rst) begin pcen = 0; mw = 0; irw = 0; rw = 0; end
    return {pcen, mw, irw, rw, iord, m2r, rd, a, bsel, psel, ac, ill};
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                      input logic rst, input int s0, input int s1);
    ent_t e;
    e.op = op; e.funct = funct; e.zero = zero; e.rst = rst; e.st0 = s0; e.st1 = s1;
    sbq.push_back(e);
  endtask

  task automatic push_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    int seq[$];
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000010: seq = '{0, 1, 11};
      default:   seq = is_legal(op) ? '{0, 1, 12} : '{0, 1};
    endcase
    foreach (seq[i]) push(op, funct, zero, 1'b0, seq[i], halted1 ? 15 : seq[i]);
    if (!is_legal(op)) halted1 = 1'b1;
  endtask

  task automatic drain();
    int cyc = 0;
    ent_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(posedge clk);
      #1;
      reset = e.rst;
      bus0.op = e.op; bus0.funct = e.funct; bus0.zero = e.zero;
      bus1.op = e.op; bus1.funct = e.funct; bus1.zero = e.zero;
      @(negedge clk);
      chk($sformatf("state0@%0d", cyc), {28'd0, bus0.state_o}, e.st0);
      chk($sformatf("outs0@%0d", cyc), {16'd0, obs0}, {16'd0, model(e.st0, e.op, e.funct, e.zero, e.rst)});
      chk($sformatf("state1@%0d", cyc), {28'd0, bus1.state_o}, e.st1);
      chk($sformatf("outs1@%0d", cyc), {16'd0, obs1}, {16'd0, model(e.st1, e.op, e.funct, e.zero, e.rst)});
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.op = 6'd0; bus0.funct = 6'd0; bus0.zero = 1'b0;
    bus1.op = 6'd0; bus1.funct = 6'd0; bus1.zero = 1'b0;

    push(6'd0, 6'd0, 1'b0, 1'b1, 0, 0);
    push(6'd0, 6'd0, 1'b0, 1'b1, 0, 0);
    push_instr(6'b100011, 6'd0, 1'b0);          // lw
    push_instr(6'b101011, 6'd0, 1'b1);          // sw
    push_instr(6'b000000, 6'b101010, 1'b0);     // slt
    push_instr(6'b000000, 6'b100000, 1'b0);     // add
    push_instr(6'b000000, 6'b100010, 1'b1);     // sub
    push_instr(6'b000000, 6'b100100, 1'b0);     // and
    push_instr(6'b000000, 6'b100101, 1'b0);     // or
    push_instr(6'b000000, 6'b111111, 1'b0);     // unknown funct still writes back
    push_instr(6'b000100, 6'd0, 1'b1);          // beq taken
    push_instr(6'b000100, 6'd0, 1'b0);          // beq not taken
    push_instr(6'b001000, 6'd0, 1'b0);          // addi
    push_instr(6'b000010, 6'd0, 1'b0);          // j
    push_instr(6'b000101, 6'd0, 1'b0);          // bne, zero=0
    push_instr(6'b000101, 6'd0, 1'b1);          // bne, zero=1
    push_instr(6'b111111, 6'd0, 1'b0);          // illegal opcode
    push_instr(6'b100011, 6'd0, 1'b0);
    // Reset raised while in MEMWR: no memwrite, FETCH afterwards.
    push(6'b101011, 6'd0, 1'b0, 1'b0, 0, halted1 ? 15 : 0);
    push(6'b101011, 6'd0, 1'b0, 1'b0, 1, halted1 ? 15 : 1);
    push(6'b101011, 6'd0, 1'b0, 1'b0, 2, halted1 ? 15 : 2);
    push(6'b101011, 6'd0, 1'b0, 1'b1, 5, halted1 ? 15 : 5);
    halted1 = 1'b0;
    push_instr(6'b001000, 6'd0, 1'b0);
    push(6'd0, 6'd0, 1'b0, 1'b0, 0, 0);

    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
